// File: rtl/qtree_run_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// qtree_run_sequencer_pkg : run-state encoding and QTree pointer helpers | rev 1.0
// =============================================================================
package qtree_run_sequencer_pkg;

   localparam int c_QTREE_PTR_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_RUN    = 3'd3,
      ST_REPORT = 3'd4
   } run_state_t;

   function automatic logic ptr_valid(input logic [c_QTREE_PTR_W-1:0] p);
      return p[0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/qtree_run_sequencer_if.sv
`default_nettype none
// =============================================================================
// qtree_run_sequencer_if : host, loader and kernel channels of the sequencer | rev 1.0
// =============================================================================
interface qtree_run_sequencer_if
   import qtree_run_sequencer_pkg::*;
#(
   parameter int NUM_INPUTS = 2,
   parameter int PTR_W      = c_QTREE_PTR_W,
   parameter int CNT_W      = 32
);
   logic                        start;
   logic                        load_en;
   logic                        root_valid;
   logic [PTR_W-1:0]            root_ptr;
   logic                        go_valid;
   logic                        go_ready;
   logic [NUM_INPUTS-1:0]       arg_valid;
   logic [NUM_INPUTS-1:0]       arg_ready;
   logic [NUM_INPUTS*PTR_W-1:0] arg_ptr;
   logic                        res_valid;
   logic [PTR_W-1:0]            res_data;
   logic                        res_ready;
   logic                        host_valid;
   logic                        host_ready;
   logic [PTR_W-1:0]            host_data;
   logic [CNT_W-1:0]            host_cycles;
   logic                        busy;
   logic                        error;

   modport master (
      input  start, root_valid, root_ptr, go_ready, arg_ready, res_valid, res_data, host_ready,
      output load_en, go_valid, arg_valid, arg_ptr, res_ready, host_valid, host_data,
             host_cycles, busy, error
   );

   modport slave (
      output start, root_valid, root_ptr, go_ready, arg_ready, res_valid, res_data, host_ready,
      input  load_en, go_valid, arg_valid, arg_ptr, res_ready, host_valid, host_data,
             host_cycles, busy, error
   );
endinterface
`default_nettype wire

// File: rtl/qtree_run_sequencer_run_chan_issuer.sv
`default_nettype none
// =============================================================================
// run_chan_issuer : one valid/ready source with done bit and held payload | rev 1.0
// =============================================================================
module run_chan_issuer
   import qtree_run_sequencer_pkg::*;
#(
   parameter int  DATA_W = c_QTREE_PTR_W,
   localparam int c_PW   = (DATA_W > 0) ? DATA_W : 1
)(
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            i_launch,
   input  wire logic            i_clear,
   input  wire logic [c_PW-1:0] i_data,
   input  wire logic            i_ready,
   output logic                 o_valid,
   output logic                 o_done,
   output logic [c_PW-1:0]      o_data
);
   logic r_valid;
   logic r_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else if (i_launch) begin
         r_valid <= 1'b1;
         r_done  <= 1'b0;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
         r_done  <= 1'b1;
      end
   end

   assign o_valid = r_valid;
   assign o_done  = r_done;

   generate
      if (DATA_W > 0) begin : g_data
         logic [c_PW-1:0] r_data;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)           r_data <= '0;
            else if (i_launch) r_data <= i_data;
         end
         assign o_data = r_data;
      end else begin : g_nodata
         logic w_data_unused;
         assign w_data_unused = ^i_data;
         assign o_data        = '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/qtree_run_sequencer.sv
`default_nettype none
// =============================================================================
// qtree_run_sequencer : load roots, issue Go/args, await result, report cycles | rev 1.0
// =============================================================================
module qtree_run_sequencer
   import qtree_run_sequencer_pkg::*;
#(
   parameter int NUM_INPUTS = 2,
   parameter int PTR_W      = c_QTREE_PTR_W,
   parameter int CNT_W      = 32,
   parameter int TIMEOUT    = 2**20
)(
   input wire logic              clk,
   input wire logic              reset,
   qtree_run_sequencer_if.master bus
);
   localparam int c_NCH  = NUM_INPUTS + 1;
   localparam int c_RC_W = $clog2(NUM_INPUTS + 1);

   run_state_t                r_state;
   run_state_t                w_state_next;
   logic [c_RC_W-1:0]         r_root_cnt;
   logic [PTR_W-1:0]          r_slot    [NUM_INPUTS];
   logic [PTR_W-1:0]          w_slot_in [NUM_INPUTS];
   logic [CNT_W-1:0]          r_cycles;
   logic                      r_error;
   logic [PTR_W-1:0]          r_host_data;
   logic [CNT_W-1:0]          r_host_cycles;

   logic [c_NCH-1:0]          w_chan_valid;
   logic [c_NCH-1:0]          w_chan_ready;
   logic [c_NCH-1:0]          w_chan_done;
   logic [c_NCH-1:0]          w_chan_fire;
   logic [NUM_INPUTS*PTR_W-1:0] w_arg_ptr;
   logic                      w_go_data_unused;

   logic w_start, w_root_wr, w_load_done, w_all_done, w_res_hs, w_timeout;
   logic w_load_en, w_res_ready, w_host_valid, w_busy;

   assign w_start     = (r_state == ST_IDLE) && bus.start;
   assign w_root_wr   = (r_state == ST_LOAD) && bus.root_valid;
   assign w_load_done = w_root_wr && (r_root_cnt == c_RC_W'(NUM_INPUTS - 1));
   assign w_chan_ready = {bus.arg_ready, bus.go_ready};
   assign w_chan_fire  = w_chan_valid & w_chan_ready;
   // A handshake completing this cycle counts as done so RUN follows the last one directly.
   assign w_all_done  = &(w_chan_done | w_chan_fire);
   assign w_res_hs    = (r_state == ST_RUN) && bus.res_valid;
   assign w_timeout   = (TIMEOUT != 0) && (r_state == ST_RUN) && (r_cycles >= CNT_W'(TIMEOUT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_load_en    = 1'b0;
      w_res_ready  = 1'b0;
      w_host_valid = 1'b0;
      w_busy       = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) w_state_next = ST_LOAD;
         end
         ST_LOAD: begin
            w_load_en = 1'b1;
            if (w_load_done) w_state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (w_all_done) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_res_ready = 1'b1;
            if (bus.res_valid)  w_state_next = ST_REPORT;
            else if (w_timeout) w_state_next = ST_IDLE;
         end
         ST_REPORT: begin
            w_host_valid = 1'b1;
            if (bus.host_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_root_cnt <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) r_slot[i] <= '0;
      end else if (w_start) begin
         r_root_cnt <= '0;
      end else if (w_root_wr) begin
         r_root_cnt <= r_root_cnt + c_RC_W'(1);
         for (int i = 0; i < NUM_INPUTS; i++)
            if (r_root_cnt == c_RC_W'(i)) r_slot[i] <= bus.root_ptr;
      end
   end

   // Last root is written on the launch edge, so the issuers see it via this bypass.
   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++)
         w_slot_in[i] = (w_root_wr && (r_root_cnt == c_RC_W'(i))) ? bus.root_ptr : r_slot[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycles <= '0;
      end else if (w_start || w_load_done) begin
         r_cycles <= '0;
      end else if ((r_state == ST_ISSUE || r_state == ST_RUN) && (r_cycles != '1)) begin
         r_cycles <= r_cycles + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_error       <= 1'b0;
         r_host_data   <= '0;
         r_host_cycles <= '0;
      end else begin
         if (w_start)                    r_error <= 1'b0;
         else if (w_timeout && !w_res_hs) r_error <= 1'b1;
         if (w_res_hs) begin
            r_host_data   <= bus.res_data;
            r_host_cycles <= r_cycles;
         end
      end
   end

   run_chan_issuer #(.DATA_W(0)) u_go (
      .clk      (clk),
      .rst      (reset),
      .i_launch (w_load_done),
      .i_clear  (w_start),
      .i_data   (1'b0),
      .i_ready  (bus.go_ready),
      .o_valid  (w_chan_valid[0]),
      .o_done   (w_chan_done[0]),
      .o_data   (w_go_data_unused)
   );

   generate
      for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_arg
         run_chan_issuer #(.DATA_W(PTR_W)) u_arg (
            .clk      (clk),
            .rst      (reset),
            .i_launch (w_load_done),
            .i_clear  (w_start),
            .i_data   (w_slot_in[g]),
            .i_ready  (bus.arg_ready[g]),
            .o_valid  (w_chan_valid[g+1]),
            .o_done   (w_chan_done[g+1]),
            .o_data   (w_arg_ptr[g*PTR_W +: PTR_W])
         );
      end
   endgenerate

   assign bus.load_en     = w_load_en;
   assign bus.go_valid    = w_chan_valid[0];
   assign bus.arg_valid   = w_chan_valid[c_NCH-1:1];
   assign bus.arg_ptr     = w_arg_ptr;
   assign bus.res_ready   = w_res_ready;
   assign bus.host_valid  = w_host_valid;
   assign bus.host_data   = r_host_data;
   assign bus.host_cycles = r_host_cycles;
   assign bus.busy        = w_busy;
   assign bus.error       = r_error;

endmodule
`default_nettype wire

// File: doc/qtree_run_sequencer.md
Name: qtree_run_sequencer

Overview:
- Sequences one benchmark run of a distilled QTree kernel: gates the AXI-stream tree loader, collects one root pointer per input tree, then issues the Go token and argument pointers over valid/ready channels.
- Waits for the kernel result, counts run cycles, and presents result plus cycle count to the host.
- Sits between the host-facing stream/result ports and the kernel's source/sink channels in the benchmark wrapper.
- Replaces ad-hoc per-channel "done" flops with one explicit FSM.

Parameters:
- NUM_INPUTS, 2, number of input trees (argument channels), 1..8
- PTR_W, 16, pointer width (Pointer_QTree_* payload incl. valid bit 0)
- CNT_W, 32, run-cycle counter width
- TIMEOUT, 2**20, RUN cycles before error; 0 disables the timeout

Ports:
- clk in 1 clock
- reset in 1 asynchronous active-high reset
- start in 1 host pulse, begins a run (sampled in IDLE only)
- load_en out 1 enables loader tready (high only in LOAD)
- root_valid in 1 loader finished one tree (tlast beat accepted)
- root_ptr in PTR_W root pointer of that tree
- go_valid out 1 sourceGo valid
- go_ready in 1 sourceGo ready
- arg_valid out NUM_INPUTS per-argument valid
- arg_ready in NUM_INPUTS per-argument ready
- arg_ptr out NUM_INPUTS*PTR_W argument pointers, slot i at [i*PTR_W +: PTR_W]
- res_valid in 1 kernel result valid
- res_data in PTR_W kernel result pointer
- res_ready out 1 ready to kernel result channel
- host_valid out 1 result available to host
- host_ready in 1 host accepts result
- host_data out PTR_W captured result
- host_cycles out CNT_W cycles from ISSUE entry to result capture
- busy out 1 state != IDLE
- error out 1 sticky timeout flag, cleared by the next start

Behaviour:
- Reset, asynchronous: state=IDLE, all outputs 0, root count=0, per-channel done bits=0, cycle counter=0, root register file=0.
- IDLE: start=1 -> LOAD next cycle; clear root count, done bits, counter and error.
- LOAD: load_en=1. Each root_valid cycle writes root_ptr to slot[count] and increments count. When the write makes count==NUM_INPUTS, go to ISSUE next cycle and drop load_en that same edge. A root_valid arriving in any other state is ignored.
- ISSUE: go_valid and each arg_valid[i] are asserted from the first ISSUE cycle, registered.
  - Each channel deasserts the cycle after its valid&ready handshake, and its done bit is set.
  - Valid never drops before the handshake completes.
  - Data is stable while valid is high.
  - Handshakes may complete in any order or all in the same cycle.
  - Once all NUM_INPUTS+1 done bits are set, go to RUN.
- Cycle counter: starts at 0 on ISSUE entry and increments every cycle in ISSUE and RUN. It saturates at all-ones and does not wrap.
- RUN: res_ready=1.
  - On res_valid&res_ready, capture res_data and the counter (value before the increment) into host_data and host_cycles, then go to REPORT.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT, set error and go to IDLE.
  - A result in the same cycle as the timeout wins: no error is raised.
- Result arrival during ISSUE: res_ready=0, so the kernel holds the result until RUN.
- REPORT: host_valid=1 with data stable. On host_ready, go to IDLE next cycle.
- start in any non-IDLE state is ignored.
- reset mid-run: immediate return to IDLE. All valids drop asynchronously.
- Latency:
  - start to load_en: 1 cycle.
  - Last root_valid to go_valid/arg_valid: 1 cycle.
  - Result handshake to host_valid: 1 cycle.

Decomposition:
- Shared benchmark package holds:
  - the run_state_t enum (IDLE, LOAD, ISSUE, RUN, REPORT);
  - the PTR_W default matching Pointer_QTree_* width;
  - the helper function ptr_valid(p) returning bit 0.
- One natural sub-module: run_chan_issuer, a single valid/ready source with a done bit and held data, instantiated NUM_INPUTS+1 times (Go instance with PTR_W=0 data).

Test Plan:
- Basic run, NUM_INPUTS=2, all readies tied 1: start; root_valid with 0x0011 then 0x0023 -> go_valid and arg_valid=2'b11 for exactly 1 cycle with arg_ptr slot0=0x0011, slot1=0x0023. res_valid with 0x0041 after 10 RUN cycles -> host_data=0x0041, host_cycles=11.
- Skewed readies: go_ready at +0, arg_ready[1] at +3, arg_ready[0] at +7 -> each valid held until its own handshake. RUN entered at cycle 8; no duplicate handshakes.
- Back-pressure: host_ready low for 20 cycles -> host_valid and data stable for 20 cycles, and a start pulse during this window is ignored. After host_ready, IDLE, and the next start works.
- Timeout, TIMEOUT=16, no result -> error=1 at counter 16, state IDLE. The next start clears error.
- Boundary: result in the same cycle as the timeout -> no error, result captured. Stray root_valid in RUN -> slots unchanged.
- Async reset asserted during ISSUE with valids high -> all outputs 0 immediately; after release, busy=0.
